// File: rtl/pixel_out_stage_if.sv
// Video bus of the pixel output stage: scan input, frame-buffer
// read port, raymarcher colour and delayed video output.
interface pixel_out_stage_if #(
  parameter int CORDW = 10
);
  logic [CORDW-1:0] sx;
  logic [CORDW-1:0] sy;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic [CORDW-1:0] read_pixel_x;
  logic [CORDW-1:0] read_pixel_y;
  logic [9:0]       i_color;
  logic [1:0]       mode;
  logic [9:0]       solid_color;
  logic [CORDW-1:0] o_sx;
  logic [CORDW-1:0] o_sy;
  logic             o_de;
  logic             o_hsync;
  logic             o_vsync;
  logic [7:0]       o_r;
  logic [7:0]       o_g;
  logic [7:0]       o_b;
  logic             o_frame_start;
  logic [15:0]      o_frame_count;

  modport master (
    output sx, sy, de, hsync, vsync,
    output i_color, mode, solid_color,
    input  read_pixel_x, read_pixel_y,
    input  o_sx, o_sy, o_de, o_hsync, o_vsync,
    input  o_r, o_g, o_b,
    input  o_frame_start, o_frame_count
  );

  modport slave (
    input  sx, sy, de, hsync, vsync,
    input  i_color, mode, solid_color,
    output read_pixel_x, read_pixel_y,
    output o_sx, o_sy, o_de, o_hsync, o_vsync,
    output o_r, o_g, o_b,
    output o_frame_start, o_frame_count
  );
endinterface

// File: rtl/pixel_out_stage.sv
// Display output stage: read-latency alignment, 3:4:3 -> 8:8:8
// expansion, blanking and frame-latched test patterns.
module pixel_out_stage #(
  parameter int READ_LAT = 2,
  parameter int H_RES    = 640,
  parameter int CORDW    = 10
) (
  input  logic             clk_pix,
  input  logic             rst_pix_n,
  pixel_out_stage_if.slave pix
);

  localparam int BAR_W = H_RES / 8;
  localparam int PXW   = $clog2(BAR_W + 1);
  localparam logic [PXW-1:0] BAR_LAST = PXW'(BAR_W - 1);

  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             de;
    logic             hs;
    logic             vs;
    logic             fs;
    logic             ray;
    logic [9:0]       col;
  } stage_t;

  localparam stage_t STAGE_RST = '{
    x:   '0,
    y:   '0,
    de:  1'b0,
    hs:  1'b1,
    vs:  1'b1,
    fs:  1'b0,
    ray: 1'b0,
    col: '0
  };

  logic           w_fs_in;
  logic [1:0]     w_mode;
  logic [1:0]     r_mode_q;
  logic           w_line0;
  logic [PXW-1:0] w_bar_px;
  logic [2:0]     w_bar_idx;
  logic           w_bar_end;
  logic [PXW-1:0] w_bar_px_nx;
  logic [2:0]     w_bar_idx_nx;
  logic [PXW-1:0] r_bar_px;
  logic [2:0]     r_bar_idx;
  logic [9:0]     w_gen;
  logic           w_ray;
  stage_t         w_in;
  stage_t         r_dl [0:READ_LAT];
  stage_t         w_out;
  logic [9:0]     r_color;
  logic [15:0]    r_frame_count;
  logic [9:0]     w_src;
  logic [7:0]     w_r8;
  logic [7:0]     w_g8;
  logic [7:0]     w_b8;

  assign pix.read_pixel_x = pix.sx;
  assign pix.read_pixel_y = pix.sy;

  // Pixel (0,0) sees the incoming mode, not the stale latch.
  assign w_fs_in = (pix.sx == '0) && (pix.sy == '0) && pix.de;
  assign w_mode  = w_fs_in ? pix.mode : r_mode_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_mode_q <= 2'd0;
    end else if (w_fs_in) begin
      r_mode_q <= pix.mode;
    end
  end

  // Counters read as zero on sx==0 so pixel 0 lands in bar 0.
  assign w_line0   = (pix.sx == '0);
  assign w_bar_px  = w_line0 ? '0 : r_bar_px;
  assign w_bar_idx = w_line0 ? 3'd0 : r_bar_idx;
  assign w_bar_end = (w_bar_px == BAR_LAST);

  always_comb begin
    w_bar_px_nx  = w_bar_px;
    w_bar_idx_nx = w_bar_idx;
    if (pix.de) begin
      if (w_bar_end) begin
        w_bar_px_nx = '0;
        if (w_bar_idx != 3'd7) begin
          w_bar_idx_nx = w_bar_idx + 3'd1;
        end
      end else begin
        w_bar_px_nx = w_bar_px + PXW'(1);
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_bar_px  <= '0;
      r_bar_idx <= 3'd0;
    end else begin
      r_bar_px  <= w_bar_px_nx;
      r_bar_idx <= w_bar_idx_nx;
    end
  end

  // Pattern colours are kept as 3:4:3 so one expander serves all.
  always_comb begin
    w_gen = '0;
    w_ray = 1'b0;
    unique case (w_mode)
      2'd0: w_ray = 1'b1;
      2'd1: w_gen = {{3{w_bar_idx[2]}},
                     {4{w_bar_idx[1]}},
                     {3{w_bar_idx[0]}}};
      2'd2: w_gen = pix.solid_color;
      2'd3: w_gen = {10{pix.sx[5] ^ pix.sy[5]}};
      default: w_gen = '0;
    endcase
  end

  always_comb begin
    w_in     = STAGE_RST;
    w_in.x   = pix.sx;
    w_in.y   = pix.sy;
    w_in.de  = pix.de;
    w_in.hs  = pix.hsync;
    w_in.vs  = pix.vsync;
    w_in.fs  = w_fs_in;
    w_in.ray = w_ray;
    w_in.col = w_gen;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      for (int i = 0; i <= READ_LAT; i++) begin
        r_dl[i] <= STAGE_RST;
      end
    end else begin
      r_dl[0] <= w_in;
      for (int i = 1; i <= READ_LAT; i++) begin
        r_dl[i] <= r_dl[i-1];
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_color <= '0;
    end else begin
      r_color <= pix.i_color;
    end
  end

  // Bump as the start pulse enters the last stage, so the new
  // count is visible alongside o_frame_start.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_frame_count <= '0;
    end else if (r_dl[READ_LAT-1].fs) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign w_out = r_dl[READ_LAT];

  always_comb begin
    w_src = w_out.ray ? r_color : w_out.col;
    w_r8  = {w_src[9:7], w_src[9:7], w_src[9:8]};
    w_g8  = {w_src[6:3], w_src[6:3]};
    w_b8  = {w_src[2:0], w_src[2:0], w_src[2:1]};
  end

  assign pix.o_sx          = w_out.x;
  assign pix.o_sy          = w_out.y;
  assign pix.o_de          = w_out.de;
  assign pix.o_hsync       = w_out.hs;
  assign pix.o_vsync       = w_out.vs;
  assign pix.o_frame_start = w_out.fs;
  assign pix.o_frame_count = r_frame_count;
  assign pix.o_r           = w_out.de ? w_r8 : 8'h00;
  assign pix.o_g           = w_out.de ? w_g8 : 8'h00;
  assign pix.o_b           = w_out.de ? w_b8 : 8'h00;

endmodule

// File: tb/tb_pixel_out_stage.sv
// Scoreboard bench for pixel_out_stage: expected pixels are queued at
// issue and a negedge monitor compares them when they come due.
module tb_pixel_out_stage;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_out_stage_if #(.CORDW(10)) bus ();
  pixel_out_stage_if #(.CORDW(10)) bus1 ();
  pixel_out_stage_if #(.CORDW(10)) bus4 ();

  pixel_out_stage #(.READ_LAT(2), .H_RES(640), .CORDW(10)) dut (
    .clk_pix   (clk),
    .rst_pix_n (rst_n),
    .pix       (bus)
  );

  pixel_out_stage #(.READ_LAT(1), .H_RES(640), .CORDW(10)) dut1 (
    .clk_pix   (clk),
    .rst_pix_n (rst_n),
    .pix       (bus1)
  );

  pixel_out_stage #(.READ_LAT(4), .H_RES(640), .CORDW(10)) dut4 (
    .clk_pix   (clk),
    .rst_pix_n (rst_n),
    .pix       (bus4)
  );

  assign bus1.sx = bus.sx;
  assign bus1.sy = bus.sy;
  assign bus1.de = bus.de;
  assign bus1.hsync = bus.hsync;
  assign bus1.vsync = bus.vsync;
  assign bus1.i_color = bus.i_color;
  assign bus1.mode = bus.mode;
  assign bus1.solid_color = bus.solid_color;
  assign bus4.sx = bus.sx;
  assign bus4.sy = bus.sy;
  assign bus4.de = bus.de;
  assign bus4.hsync = bus.hsync;
  assign bus4.vsync = bus.vsync;
  assign bus4.i_color = bus.i_color;
  assign bus4.mode = bus.mode;
  assign bus4.solid_color = bus.solid_color;

  function automatic logic [9:0] pat(input logic [9:0] x,
                                     input logic [9:0] y);
    if (x == 10'd5 && y == 10'd7) return 10'b100_1010_111;
    return x * 10'd13 + y * 10'd7;
  endfunction

  function automatic logic [23:0] ex(input logic [9:0] c);
    return {c[9:7], c[9:7], c[9:8], c[6:3], c[6:3],
            c[2:0], c[2:0], c[2:1]};
  endfunction

  // Raymarcher stand-in: answers the read address two cycles later.
  logic [9:0] a1x = '0, a1y = '0, a2x = '0, a2y = '0;
  always @(posedge clk) begin
    a1x <= bus.read_pixel_x;
    a1y <= bus.read_pixel_y;
    a2x <= a1x;
    a2y <= a1y;
  end
  assign bus.i_color = pat(a2x, a2y);

  typedef struct {
    int          due;
    string       tag;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [15:0] fc;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    int   due;
    logic hs;
  } sexp_t;

  exp_t  q[$];
  sexp_t qa1[$];
  sexp_t qa4[$];

  int          m_mode = 0;
  logic [15:0] fc_m = '0;
  logic        in_rst = 1'b1;
  logic        prev_hs = 1'b1;

  task automatic drive(input int x, input int y, input logic de_i,
                       input int md, input logic hs_i = 1'b1,
                       input string tag = "px",
                       input logic frc = 1'b0,
                       input logic [23:0] rgb_h = '0);
    exp_t e;
    int   eff;
    int   bar;
    logic fs;
    bus.sx    = 10'(x);
    bus.sy    = 10'(y);
    bus.de    = de_i;
    bus.hsync = hs_i;
    bus.vsync = 1'b1;
    bus.mode  = 2'(md);
    fs  = (x == 0) && (y == 0) && de_i;
    eff = fs ? md : m_mode;
    if (fs) begin
      m_mode = md;
      fc_m   = fc_m + 16'd1;
    end
    e.due = cyc + 3;
    e.tag = tag;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.de  = de_i;
    e.hs  = hs_i;
    e.vs  = 1'b1;
    e.fs  = fs;
    e.fc  = fc_m;
    e.rgb = '0;
    if (de_i) begin
      case (eff)
        0: e.rgb = ex(pat(10'(x), 10'(y)));
        1: begin
          bar = x / 80;
          if (bar > 7) bar = 7;
          e.rgb = {(bar & 4) != 0 ? 8'hFF : 8'h00,
                   (bar & 2) != 0 ? 8'hFF : 8'h00,
                   (bar & 1) != 0 ? 8'hFF : 8'h00};
        end
        2: e.rgb = ex(bus.solid_color);
        default:
          e.rgb = (((x / 32) % 2) != ((y / 32) % 2)) ?
                  24'hFFFFFF : 24'h000000;
      endcase
    end
    if (frc) e.rgb = rgb_h;
    if (!in_rst) begin
      q.push_back(e);
      if (prev_hs && !hs_i) begin
        qa1.push_back('{cyc + 1, 1'b1});
        qa1.push_back('{cyc + 2, 1'b0});
        qa4.push_back('{cyc + 4, 1'b1});
        qa4.push_back('{cyc + 5, 1'b0});
      end
    end
    prev_hs = hs_i;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      ntests++;
      nfail++;
      $display("FAIL %s missed: due=%0d now=%0d", e.tag, e.due, cyc);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ntests++;
      if (bus.o_sx !== e.x || bus.o_sy !== e.y ||
          bus.o_de !== e.de || bus.o_hsync !== e.hs ||
          bus.o_vsync !== e.vs || bus.o_frame_start !== e.fs ||
          bus.o_frame_count !== e.fc ||
          {bus.o_r, bus.o_g, bus.o_b} !== e.rgb) begin
        nfail++;
        $display({"FAIL %s cyc=%0d got x=%0d y=%0d de=%b hs=%b vs=%b",
                  " fs=%b fc=%h rgb=%h exp x=%0d y=%0d de=%b hs=%b",
                  " vs=%b fs=%b fc=%h rgb=%h"},
                 e.tag, cyc, bus.o_sx, bus.o_sy, bus.o_de,
                 bus.o_hsync, bus.o_vsync, bus.o_frame_start,
                 bus.o_frame_count, {bus.o_r, bus.o_g, bus.o_b},
                 e.x, e.y, e.de, e.hs, e.vs, e.fs, e.fc, e.rgb);
      end
    end
  end

  always @(negedge clk) begin
    sexp_t s;
    if (qa1.size() > 0 && qa1[0].due <= cyc) begin
      s = qa1.pop_front();
      ntests++;
      if (s.due != cyc || bus1.o_hsync !== s.hs) begin
        nfail++;
        $display("FAIL hsync_lat1 cyc=%0d got %b want %b at %0d",
                 cyc, bus1.o_hsync, s.hs, s.due);
      end
    end
    if (qa4.size() > 0 && qa4[0].due <= cyc) begin
      s = qa4.pop_front();
      ntests++;
      if (s.due != cyc || bus4.o_hsync !== s.hs) begin
        nfail++;
        $display("FAIL hsync_lat4 cyc=%0d got %b want %b at %0d",
                 cyc, bus4.o_hsync, s.hs, s.due);
      end
    end
  end

  task automatic chk_rst(input string tag);
    logic [63:0] got;
    logic [63:0] want;
    got = {bus.o_sx, bus.o_sy, bus.o_de, bus.o_hsync, bus.o_vsync,
           bus.o_frame_start, bus.o_frame_count,
           bus.o_r, bus.o_g, bus.o_b};
    want = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 24'd0};
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    in_rst = 1'b1;
    q.delete();
    m_mode = 0;
    fc_m   = '0;
    #1;
    chk_rst("rst_async");
    for (int i = 0; i < n; i++) begin
      bus.sx          = 10'($urandom_range(0, 799));
      bus.sy          = 10'($urandom_range(0, 524));
      bus.de          = 1'($urandom);
      bus.hsync       = 1'($urandom);
      bus.vsync       = 1'($urandom);
      bus.mode        = 2'($urandom);
      bus.solid_color = 10'($urandom);
      @(posedge clk);
      #1;
      chk_rst("rst_hold");
    end
    prev_hs = 1'b1;
    rst_n   = 1'b1;
    in_rst  = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b1;
    bus.sx          = '0;
    bus.sy          = '0;
    bus.de          = 1'b0;
    bus.hsync       = 1'b1;
    bus.vsync       = 1'b1;
    bus.mode        = 2'd0;
    bus.solid_color = '0;
    #2;
    do_reset(4);

    drive(5, 7, 1'b1, 0, 1'b1, "expand_5_7", 1'b1, 24'h92AAFF);
    drive(5, 7, 1'b0, 0, 1'b1, "blank_5_7", 1'b1, 24'h000000);
    for (int i = 0; i < 3; i++) drive(700, 500, 1'b0, 0);

    // Colour bars, mode switched on pixel (0,0) itself.
    for (int x = 0; x < 640; x++) begin
      if (x == 0 || x == 79)
        drive(x, 0, 1'b1, 1, 1'b1, "bar0", 1'b1, 24'h000000);
      else if (x == 80 || x == 159)
        drive(x, 0, 1'b1, 1, 1'b1, "bar1", 1'b1, 24'h0000FF);
      else if (x == 560 || x == 639)
        drive(x, 0, 1'b1, 1, 1'b1, "bar7", 1'b1, 24'hFFFFFF);
      else
        drive(x, 0, 1'b1, 1, 1'b1, "bars");
    end
    for (int x = 640; x < 648; x++)
      drive(x, 0, 1'b0, 1, (x >= 642 && x < 646) ? 1'b0 : 1'b1,
            "hblank");
    for (int x = 0; x < 10; x++)
      drive(x, 1, 1'b1, 1, 1'b1, "bar_clear", 1'b1, 24'h000000);

    // Mode change mid-frame must not take effect.
    drive(0, 0, 1'b1, 0, 1'b1, "latch_f0");
    for (int x = 0; x <= 40; x++)
      drive(x, 100, 1'b1, 3, 1'b1, "latch_hold");
    drive(650, 100, 1'b0, 3);
    for (int x = 0; x <= 40; x++) begin
      if (x == 0)
        drive(x, 0, 1'b1, 3, 1'b1, "latch_px0", 1'b1, 24'h000000);
      else if (x == 32)
        drive(x, 0, 1'b1, 3, 1'b1, "latch_px32", 1'b1, 24'hFFFFFF);
      else
        drive(x, 0, 1'b1, 3, 1'b1, "checker");
    end

    bus.solid_color = 10'b100_1010_111;
    for (int x = 0; x < 4; x++)
      drive(x, 0, 1'b1, 2, 1'b1, "solid", 1'b1, 24'h92AAFF);
    drive(4, 0, 1'b1, 1, 1'b1, "solid_hold", 1'b1, 24'h92AAFF);

    // Mid-frame reset, then wrap the frame counter.
    do_reset(3);
    for (int i = 0; i < 65535; i++) drive(0, 0, 1'b1, 0, 1'b1, "preload");
    for (int i = 0; i < 4; i++) drive(1, 0, 1'b0, 0);
    drive(0, 0, 1'b1, 0, 1'b1, "fc_wrap", 1'b1, 24'h000000);
    for (int x = 1; x < 5; x++) drive(x, 0, 1'b1, 0, 1'b1, "fs_single");
    for (int i = 0; i < 4; i++) drive(700, 0, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && qa1.size() == 0 && qa4.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    if (q.size() != 0 || qa1.size() != 0 || qa4.size() != 0) begin
      ntests++;
      nfail++;
      $display("FAIL drain left %0d/%0d/%0d want 0",
               q.size(), qa1.size(), qa4.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
